// File: rtl/memory_buffer.sv
// rtl/memory_buffer.sv - capture/replay buffer between host-command FIFO and readback path
// Optional feature macro: MEMBUF_DROP_CNT_EN (adds 16-bit saturating drop_cnt output)
module memory_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RING   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_empty,
    output logic              din_read,
    input  logic [DATA_W-1:0] din,
    input  logic              dout_read,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    input  logic              zero,
    input  logic              clear,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow
`ifdef MEMBUF_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int unsigned     DEPTH_I   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH     = DEPTH_I[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE_C     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic            RING_MODE = (RING != 0);

    logic [DATA_W-1:0] mem_q [DEPTH_I];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   count_vis_q, count_vis_d;
    logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
    logic              overflow_q, overflow_d;
    logic              stale_q, stale_d;
    logic [DATA_W-1:0] dout_q;

    logic              full_w;
    logic              wr_en;
    logic              overwrite;
    logic              refused;
    logic              pop;
    logic [ADDR_W-1:0] start_w;

    // Write acceptance: linear mode refuses when full, ring mode always accepts; clear wins
    always_comb begin
        full_w    = (count_q == DEPTH);
        wr_en     = ~clear & ~din_empty & (RING_MODE | ~full_w);
        overwrite = wr_en & full_w;
        refused   = ~clear & ~din_empty & full_w & ~RING_MODE;
        // Once the ring has wrapped the oldest word sits where the next write lands
        start_w   = full_w ? wr_ptr_q : '0;
        // The last presented address was being written: dout holds the old slot content
        valid     = (rd_idx_q < count_vis_q) & ~stale_q;
        pop       = dout_read & valid;
    end

    // Next-state for pointers, occupancy and replay position (clear > zero > pop)
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        rd_idx_d    = rd_idx_q;
        rd_addr_d   = rd_addr_q;
        count_vis_d = count_q;
        if (clear) begin
            wr_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            rd_idx_d    = '0;
            rd_addr_d   = '0;
            count_vis_d = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + ONE_A;
                if (!full_w) begin
                    count_d = count_q + ONE_C;
                end
            end
            if (overwrite || refused) begin
                overflow_d = 1'b1;
            end
            if (zero) begin
                rd_idx_d  = '0;
                rd_addr_d = start_w;
            end else if (pop) begin
                rd_idx_d  = rd_idx_q + ONE_C;
                rd_addr_d = rd_addr_q + ONE_A;
            end
            // The oldest word is being destroyed: either skip past it (if it was
            // next to replay) or keep pointing at the same word, now one closer to start
            if (overwrite) begin
                if (rd_idx_d == '0) begin
                    rd_addr_d = rd_addr_d + ONE_A;
                end else begin
                    rd_idx_d = rd_idx_d - ONE_C;
                end
            end
        end
        stale_d = wr_en & (rd_addr_d == wr_ptr_q);
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_addr_q   <= '0;
            count_q     <= '0;
            count_vis_q <= '0;
            rd_idx_q    <= '0;
            overflow_q  <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_addr_q   <= rd_addr_d;
            count_q     <= count_d;
            count_vis_q <= count_vis_d;
            rd_idx_q    <= rd_idx_d;
            overflow_q  <= overflow_d;
            stale_q     <= stale_d;
        end
    end

    // RAM write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // RAM read port: registered, reads the address presented this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= mem_q[rd_addr_d];
        end
    end

`ifdef MEMBUF_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Lost-word counter, saturating
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            drop_cnt_d = '0;
        end else if ((overwrite || refused) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Lost-word counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign din_read = wr_en;
    assign dout     = dout_q;
    assign count    = count_q;
    assign full     = full_w;
    assign overflow = overflow_q;

endmodule

// File: doc/memory_buffer.md
Name: memory_buffer

Overview:
- Parametrised capture/replay buffer between the host-command FIFO (show-ahead) and the readback path.
- Captures words from the upstream FIFO into on-chip RAM, then replays them from the start on request.
- Adds configurable width and depth, linear or ring capture, an occupancy count, an overflow flag and an explicit clear.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words.
- RING, 0, capture mode. 0 = linear: stop accepting when full. 1 = ring: overwrite the oldest word when full.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din_empty  in  1  upstream FIFO empty.
- din_read  out  1  pop of upstream FIFO; the word on din is consumed in the same cycle.
- din  in  DATA_W  upstream data, valid whenever din_empty=0.
- dout_read  in  1  consumer pop; effective only when valid=1.
- dout  out  DATA_W  current replay word.
- valid  out  1  dout holds an unread word.
- zero  in  1  rewind replay to the oldest stored word.
- clear  in  1  synchronous flush: empty the buffer.
- count  out  ADDR_W+1  words stored, range 0..DEPTH.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; a write occurred while full (ring overwrite) or a word was refused while full (linear).

Behaviour:
- Reset (rst_n=0, asynchronous): write pointer, read index and count = 0; valid = 0; full = 0; overflow = 0; dout = 0.
- Storage: inferred simple dual-port RAM with synchronous read and one-cycle read latency. No vendor cores.
- Write rules:
  - Linear mode: din_read = ~din_empty & ~full.
  - Ring mode: din_read = ~din_empty.
  - Each write stores din at wr_ptr; wr_ptr increments modulo DEPTH; count increments, saturating at DEPTH.
- Overflow:
  - Ring mode: a write while full advances the oldest pointer (oldest = wr_ptr once wrapped) and sets overflow.
  - Linear mode: ~din_empty while full sets overflow; din_read stays 0.
- Read address: RAM read address = start when zero; rd_addr+1 on an effective pop; otherwise rd_addr. start = 0 (linear or unwrapped) or oldest (ring, wrapped).
- dout: always reflects the word at rd_addr one cycle after that address is presented. An effective pop at cycle N presents the next word at N+1, so a sustained one-word-per-cycle pop rate is possible.
- rd_idx: replay position counted from start, width ADDR_W+1.
- valid: valid = (rd_idx < count_vis), where count_vis is count delayed one cycle. A word written at cycle N can raise valid at N+2 at the earliest.
- Pop: dout_read & valid increments rd_idx. Popping the last visible word drops valid at N+1.
- Pop while invalid: ignored; no pointer change.
- zero at N: rd_idx = 0 and rd_addr = start at N+1; dout = oldest word at N+1; valid(N+1) = (count_vis > 0).
- Ring overwrite during replay: if rd_idx points at an overwritten slot, the read index is advanced to the new oldest word. No stale data is replayed as new.
- clear at N: wr_ptr, rd_idx, count and overflow = 0; valid = 0 from N+1.
- clear and a write in the same cycle: the write is discarded and din_read = 0.
- Priority: clear > zero > pop. Writes proceed concurrently with zero or pop.
- Arithmetic: pointer wrap is natural ADDR_W-bit rollover. count and rd_idx are ADDR_W+1 bits and never exceed DEPTH.

Optional Feature:
- Macro: MEMBUF_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt, 16 bits.
  - Increments on every overwritten word (ring) or refused word (linear); saturates at 0xFFFF.
  - Cleared by rst_n or clear.
- Not defined: the port and its logic are absent; overflow is the only loss indicator.

Test Plan:
- Reset then 4 writes (0xA0..0xA3), then zero -> count=4; valid=1 with dout=0xA0 one cycle after zero; 4 back-to-back pops return 0xA0..0xA3; valid=0 after the 4th pop.
- Linear, ADDR_W=3: push 10 words -> din_read low after 8; count=8; full=1; overflow=1; replay gives words 0..7.
- RING=1, ADDR_W=3: push values 1..11, zero -> replay 4..11; overflow=1; count=8.
- Write at cycle N into an empty buffer with zero held -> valid first high at N+2.
- clear asserted mid-replay with a write pending -> din_read=0 that cycle; count=0; valid=0 the next cycle; overflow=0.
- rst_n pulsed low mid-write, asynchronously -> all outputs return to reset values immediately; a subsequent single write plus zero replays only that word.
